// File: rtl/cnu_6.sv
// cnu_6: serial min-sum check-node unit. It collects DEG messages, then emits DEG check-to-variable messages.
// Offset min-sum correction is enabled when the macro CNU_OFFSET_MS_EN is defined.
module cnu_6 #(
    parameter int DW     = 32,
    parameter int DEG    = 6,
    parameter int OFFSET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] Q_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] R_out,
    output logic [2:0]           R_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 check_ok
);

    // Handshake: a word transfers on a rising edge where valid and ready are both high.
    // valid never depends on ready, and R_out/R_idx hold while out_valid is high and out_ready is low.

    localparam logic [DW-1:0] MAG_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [2:0]    LAST    = 3'(DEG - 1);

`ifdef CNU_OFFSET_MS_EN
    localparam logic [DW-1:0] OFF_AMT = DW'(OFFSET);
`else
    localparam logic [DW-1:0] OFF_AMT = DW'(0 * OFFSET);
`endif

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]     cnt;
    logic [DW-1:0]  min1;
    logic [DW-1:0]  min2;
    logic [2:0]     idx_min1;
    logic [DEG-1:0] signs;
    logic           sgn_tot;

    logic           accept;
    logic           emit_hs;
    logic           sgn_in;
    logic [DW-1:0]  neg_in;
    logic [DW-1:0]  mag_in;

    logic [DW-1:0]        sel_mag;
    logic [DW-1:0]        adj_mag;
    logic                 r_sign;
    logic signed [DW-1:0] r_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == LAST)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && (cnt == LAST)) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign accept  = (state == COLLECT) && in_valid;
    assign emit_hs = (state == EMIT) && out_ready;

    // |Q_in| saturates: the most negative input maps to the largest positive magnitude.
    assign sgn_in = Q_in[DW-1];
    assign neg_in = -Q_in;
    assign mag_in = !sgn_in ? Q_in : (neg_in[DW-1] ? MAG_MAX : neg_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            min1     <= MAG_MAX;
            min2     <= MAG_MAX;
            idx_min1 <= '0;
            signs    <= '0;
            sgn_tot  <= 1'b0;
            check_ok <= 1'b0;
        end else if (accept) begin
            signs[cnt] <= sgn_in;
            sgn_tot    <= sgn_tot ^ sgn_in;
            // Strict compares keep the earlier edge as idx_min1 on ties.
            if (mag_in < min1) begin
                min2     <= min1;
                min1     <= mag_in;
                idx_min1 <= cnt;
            end else if (mag_in < min2) begin
                min2 <= mag_in;
            end
            if (cnt == LAST) begin
                cnt      <= '0;
                check_ok <= ~(sgn_tot ^ sgn_in);
            end else begin
                cnt <= cnt + 3'd1;
            end
        end else if (emit_hs) begin
            if (cnt == LAST) begin
                cnt      <= '0;
                min1     <= MAG_MAX;
                min2     <= MAG_MAX;
                idx_min1 <= '0;
                signs    <= '0;
                sgn_tot  <= 1'b0;
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // The edge holding the minimum sees the second minimum; every other edge sees the minimum.
    always_comb begin
        sel_mag = (cnt == idx_min1) ? min2 : min1;
        adj_mag = (sel_mag > OFF_AMT) ? (sel_mag - OFF_AMT) : '0;
        r_sign  = signs[cnt] ^ sgn_tot;
        r_val   = r_sign ? -$signed(adj_mag) : $signed(adj_mag);
    end

    assign R_out = out_valid ? r_val : '0;
    assign R_idx = out_valid ? cnt : 3'd0;

endmodule

// File: tb/tb_cnu_6.sv
// tb_cnu_6: directed frames checked against an extrinsic min-sum model and hand-computed literals.
module tb_cnu_6;
  localparam int DW = 32;
  localparam int DEG = 6;
  localparam int OFFSET = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [DW-1:0] Q_in = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [DW-1:0] R_out;
  logic [2:0] R_idx;
  logic out_valid;
  logic out_ready = 1'b1;
  logic check_ok;

  int errors = 0;
  int checks = 0;

  logic [DW+2:0] exp_q[$];
  longint frame_q[$];
  logic exp_ok = 1'b0;
  longint got_r[DEG];
  bit bp_en = 1'b0;
  int stall_cnt = 0;
  bit prev_stall = 1'b0;
  logic signed [DW-1:0] prev_r;
  logic [2:0] prev_idx;

  cnu_6 #(.DW(DW), .DEG(DEG), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst), .Q_in(Q_in), .in_valid(in_valid), .in_ready(in_ready),
    .R_out(R_out), .R_idx(R_idx), .out_valid(out_valid), .out_ready(out_ready),
    .check_ok(check_ok)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // model: each edge gets the minimum |Q| and sign parity of the other edges
  function automatic longint sat_abs(input longint v);
    longint maxv = (longint'(1) <<< (DW - 1)) - 1;
    longint a = (v < 0) ? -v : v;
    return (a > maxv) ? maxv : a;
  endfunction

  task automatic model_accept(input longint q);
    longint m;
    bit s;
    bit tot;
    logic [DW-1:0] v;
    frame_q.push_back(q);
    if (frame_q.size() == DEG) begin
      tot = 1'b0;
      for (int i = 0; i < DEG; i++) begin
        m = (longint'(1) <<< (DW - 1)) - 1;
        s = 1'b0;
        for (int j = 0; j < DEG; j++) begin
          if (j != i) begin
            if (sat_abs(frame_q[j]) < m) m = sat_abs(frame_q[j]);
            s = s ^ (frame_q[j] < 0);
          end
        end
`ifdef CNU_OFFSET_MS_EN
        m = (m > OFFSET) ? m - OFFSET : 0;
`endif
        v = DW'(s ? -m : m);
        exp_q.push_back({3'(i), v});
        tot = tot ^ (frame_q[i] < 0);
      end
      exp_ok = ~tot;
      frame_q.delete();
    end
  endtask

  // backpressure: hold out_ready low for 3 cycles when edge 2 is presented
  always @(posedge clk) begin
    #1;
    if (bp_en && out_valid && R_idx == 3'd2 && stall_cnt < 3) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clk) begin
    logic [DW+2:0] e;
    if (!rst) begin
      check("check_ok_track", check_ok, exp_ok);
      if (out_valid) begin
        check("in_ready_in_emit", in_ready, 0);
        if (prev_stall) begin
          check("hold_r_out", R_out, prev_r);
          check("hold_r_idx", R_idx, prev_idx);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("r_idx", R_idx, e[DW+2:DW]);
            check("r_out", R_out, longint'($signed(e[DW-1:0])));
            if (R_idx < DEG) got_r[R_idx] = longint'(R_out);
          end
        end
        prev_stall = !out_ready;
        prev_r = R_out;
        prev_idx = R_idx;
      end else begin
        check("in_ready_in_collect", in_ready, 1);
        prev_stall = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic send(input longint q, input int gap);
    bit done = 1'b0;
    in_valid = 1'b1;
    Q_in = DW'(q);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    Q_in = '0;
    if (!done) check("send_timeout", 0, 1);
    else model_accept(q);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    check("drain_done", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string name, input longint q[DEG], input longint lit[DEG],
                           input logic lit_ok, input int gap);
    for (int i = 0; i < DEG; i++) got_r[i] = -64'sd999999999999;
    for (int i = 0; i < DEG; i++) send(q[i], gap);
    drain();
    for (int i = 0; i < DEG; i++) check({name, "_lit_r"}, got_r[i], lit[i]);
    check({name, "_lit_ok"}, check_ok, lit_ok);
  endtask

  task automatic model_clear();
    frame_q.delete();
    exp_q.delete();
    exp_ok = 1'b0;
  endtask

  initial begin
    longint qa[DEG] = '{5, -3, 7, 2, -9, 4};
    longint qb[DEG] = '{-4, 4, 6, 8, 10, 12};
    longint qc[DEG] = '{-64'sd2147483648, 1, 1, 1, 1, 1};
    longint qg[DEG] = '{100, 50, -50, 200, -1, 3};
    longint qf[DEG] = '{1, -2, 3, -4, 5, -6};
`ifdef CNU_OFFSET_MS_EN
    longint la[DEG] = '{1, -1, 1, 2, -1, 1};
    longint lb[DEG] = '{3, -3, -3, -3, -3, -3};
    longint lc[DEG] = '{0, 0, 0, 0, 0, 0};
    longint lg[DEG] = '{0, 0, 0, 0, -2, 0};
    longint lf[DEG] = '{-1, 0, 0, 0, 0, 0};
`else
    longint la[DEG] = '{2, -2, 2, 3, -2, 2};
    longint lb[DEG] = '{4, -4, -4, -4, -4, -4};
    longint lc[DEG] = '{1, -1, -1, -1, -1, -1};
    longint lg[DEG] = '{1, 1, -1, 1, -3, 1};
    longint lf[DEG] = '{-2, 1, -1, 1, -1, 1};
`endif

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_r_out", R_out, 0);
    check("rst_r_idx", R_idx, 0);
    check("rst_check_ok", check_ok, 0);
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    run_frame("basic", qa, la, 1'b1, 0);
    run_frame("tie_sign", qb, lb, 1'b0, 0);
    run_frame("saturate", qc, lc, 1'b0, 0);

    bp_en = 1'b1;
    stall_cnt = 0;
    run_frame("backpressure", qa, la, 1'b1, 0);
    bp_en = 1'b0;
    check("bp_stall_cycles", stall_cnt, 3);

    run_frame("idle_gaps", qg, lg, 1'b1, 2);

    // partial frame discarded by reset
    send(10, 0);
    send(-20, 0);
    send(30, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_r_out", R_out, 0);
    check("mid_rst_r_idx", R_idx, 0);
    check("mid_rst_check_ok", check_ok, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    run_frame("after_reset", qf, lf, 1'b0, 0);

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
